// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed big-endian byte image into instruction memory, holding the core until complete.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic        accept;
    logic        start_ok;
    logic [15:0] len_n;
    logic        len_ok;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && !busy;
    assign len_n     = {len_q[15:8], rx_data};
    assign len_ok    = (len_n != 16'd0) && ({1'b0, len_n} <= DEPTH);
    // The word being written this cycle is the last one of the image.
    assign last_word = (17'(addr_q) + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) state_d = len_ok ? S_DATA : S_ERR;
            S_DATA: begin
                // Leave only after the final write strobe, so the image is committed before release.
                if (we_q && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                busy     = 1'b1;
                rx_ready = !we_q;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                busy     = 1'b1;
                rx_ready = !we_q;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        if (start_ok) begin
            byte_cnt_d = 2'd0;
            word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_d      = 8'd0;
`endif
        end
        if (accept) begin
            case (state_q)
                S_LEN_HI: len_d[15:8] = rx_data;
                S_LEN_LO: len_d[7:0]  = rx_data;
                S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q;
                        wdata_d    = {asm_q, rx_data};
                        word_idx_d = word_idx_q + 1'b1;
                    end else begin
                        asm_d = {asm_q[15:0], rx_data};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= 8'd0;
`endif
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against a frame-level reference model.
module tb_imem_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW+31:0] obs_q[$];
    logic [AW+31:0] exp_q[$];
    bit             exp_ok;
    int             viol_rdy  = 0;
    int             viol_hold = 0;
    bq_t            frm;
    logic [31:0]    wds[$];

    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back({imem_addr, imem_wdata});
            if (rx_ready)   viol_rdy++;
            if (!core_hold) viol_hold++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the frame by its rules, producing the write list and the final outcome.
    task automatic model(input bq_t f);
        int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
`endif
        exp_q.delete();
        n = int'({f[0], f[1]});
        if (n == 0 || n > DEPTH) begin
            exp_ok = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_q.push_back({AW'(i), f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 2; i < 2 + 4 * n; i++) x = x ^ f[i];
        exp_ok = (f[2+4*n] == x);
`else
        exp_ok = 1'b1;
`endif
    endtask

    task automatic build_frame(input bit bad);
        logic [15:0] n;
        logic [7:0]  x;
        n = 16'(wds.size());
        x = 8'd0;
        frm.delete();
        frm.push_back(n[15:8]);
        frm.push_back(n[7:0]);
        foreach (wds[i]) begin
            logic [31:0] w;
            w = wds[i];
            frm.push_back(w[31:24]); frm.push_back(w[23:16]);
            frm.push_back(w[15:8]);  frm.push_back(w[7:0]);
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frm.push_back(bad ? (x ^ 8'h01) : x);
`else
        if (bad) x = 8'd0;
`endif
    endtask

    task automatic prep();
        obs_q.delete();
        viol_rdy  = 0;
        viol_hold = 0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, "_rdy_after_start"}, 64'(rx_ready), 64'd1);
    endtask

    task automatic send(input string tag, input int nbytes, input int gap_pct, input bit noise);
        int idx = 0;
        int budget = 0;
        while (idx < nbytes && budget < 20000) begin
            @(negedge clk);
            start    = (noise && $urandom_range(9) == 0);
            rx_valid = ($urandom_range(99) >= gap_pct);
            rx_data  = frm[idx];
            if (rx_valid && rx_ready) idx++;
            budget++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        chk({tag, "_bytes_sent"}, 64'(idx), 64'(nbytes));
    endtask

    task automatic wait_end(input string tag);
        int c = 0;
        while (!(done || error) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_end_timeout"}, 64'(c < 100), 64'd1);
    endtask

    task automatic run_check(input string tag);
        int nobs;
        chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < obs_q.size()) chk($sformatf("%s_write%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        chk({tag, "_done"}, 64'(done), 64'(exp_ok));
        chk({tag, "_error"}, 64'(error), 64'(!exp_ok));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_ok));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy_overlap_we"}, 64'(viol_rdy), 64'd0);
        chk({tag, "_release_during_we"}, 64'(viol_hold), 64'd0);
        // Bytes offered after the load ends must be refused.
        nobs = obs_q.size();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        chk({tag, "_extra_rdy"}, 64'(rx_ready), 64'd0);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk({tag, "_extra_no_write"}, 64'(obs_q.size()), 64'(nobs));
        chk({tag, "_extra_done_held"}, 64'(done), 64'(exp_ok));
    endtask

    task automatic load(input string tag, input int gap_pct, input bit noise);
        model(frm);
        prep();
        pulse_start(tag);
        send(tag, frm.size(), gap_pct, noise);
        wait_end(tag);
        run_check(tag);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #12;
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_hold", 64'(core_hold), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        #10 reset = 1'b1;
        @(negedge clk);

        wds = '{32'h12345678, 32'h9ABCDEF0};
        build_frame(1'b0);
        load("two_word", 0, 1'b0);
        chk("two_word_w0_const", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({8'h00, 32'h12345678}));
        chk("two_word_w1_const", 64'(obs_q.size() > 1 ? obs_q[1] : '0), 64'({8'h01, 32'h9ABCDEF0}));

`ifdef IMEM_LOADER_CHECKSUM_EN
        wds = '{32'h01020304};
        build_frame(1'b1);
        chk("bad_chk_byte", 64'(frm[6]), 64'h05);
        load("bad_chk", 0, 1'b0);
        chk("bad_chk_error_const", 64'(error), 64'd1);
`endif

        for (int k = 0; k < 2; k++) begin
            string tag;
            tag = (k == 0) ? "len_zero" : "len_over";
            frm.delete();
            frm.push_back(k == 0 ? 8'h00 : 8'h01);
            frm.push_back(k == 0 ? 8'h00 : 8'h01);
            model(frm);
            prep();
            pulse_start(tag);
            send(tag, 2, 0, 1'b0);
            chk({tag, "_error_next_cycle"}, 64'(error), 64'd1);
            run_check(tag);
        end

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            wds.delete();
            for (int i = 0; i < n; i++) wds.push_back($urandom);
            build_frame($urandom_range(3) == 0);
            load($sformatf("rand%0d", r), 40, 1'b1);
        end

        wds.delete();
        for (int i = 0; i < DEPTH; i++) wds.push_back(32'(i) * 32'h01010101 + 32'h00010203);
        build_frame(1'b0);
        load("full_depth", 10, 1'b0);
        chk("full_depth_last_addr", 64'(obs_q.size() > 0 ? obs_q[obs_q.size()-1][AW+31:32] : '0),
            64'(DEPTH - 1));

        wds = '{32'hCAFEF00D, 32'h0BADBEEF};
        build_frame(1'b0);
        model(frm);
        prep();
        pulse_start("mid_rst");
        send("mid_rst", 6, 0, 1'b0);
        chk("mid_rst_we_before", 64'(imem_we), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_core_hold", 64'(core_hold), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_we", 64'(imem_we), 64'd0);
        chk("mid_rst_rdy", 64'(rx_ready), 64'd0);
        chk("mid_rst_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load("reload", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
